issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural GPRs tracked.
REQ-002 SHALL have parameter MAX_INFL, default 3, maximum in-flight writers per register (EX, MEM, WB slots).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ds_rs, ds_rt  input  5 each  ID source register numbers.
REQ-006 SHALL have ports ds_rs_used, ds_rt_used  input  1 each  source actually read by the decoded instruction.
REQ-007 SHALL have ports ds_dest  input  5, ds_gr_we  input  1, ds_is_load  input  1  ID destination, write enable, load flag.
REQ-008 SHALL have port ds_fire  input  1  ID->EX handshake taken (ds_to_es_valid && es_allowin).
REQ-009 SHALL have port es_fire  input  1  EX->MS handshake taken.
REQ-010 SHALL have ports ws_retire  input  1, ws_dest  input  5  WB commits a writing instruction this cycle.
REQ-011 SHALL have port flush  input  1  discard all in-flight state.
REQ-012 SHALL have ports ds_stall  output  1, rs_pending/rt_pending  output  1 each, infl_cnt  output  2  (total writers in flight).

Function
REQ-013 SHALL keep per-register pending counter cnt[r] (2 bits) and a load-in-EX record {lie_valid, lie_dest}.
REQ-014 On ds_fire with ds_gr_we and ds_dest!=0, cnt[ds_dest] SHALL increment at next edge.
REQ-015 On ws_retire with ws_dest!=0, cnt[ws_dest] SHALL decrement at next edge; same-cycle issue+retire on one register SHALL leave cnt unchanged.
REQ-016 Register 0 SHALL never be tracked; cnt[0] reads 0 always.
REQ-017 On ds_fire with ds_is_load, lie SHALL load {1, ds_dest}; otherwise on es_fire lie_valid SHALL clear; ds_fire of a load and es_fire same cycle: new load wins.
REQ-018 rs_pending SHALL equal ds_rs_used && cnt[ds_rs]!=0 (combinational); rt_pending likewise.
REQ-019 ds_stall SHALL assert combinationally when (a) lie_valid && lie_dest!=0 && lie_dest matches a used source (load-use), or (b) ds_gr_we && cnt[ds_dest]==MAX_INFL (WAW overflow).
REQ-020 ds_stall SHALL NOT depend on ds_fire (no combinational loop); ID gates ds_ready_go with !ds_stall.
REQ-021 infl_cnt SHALL count issued-not-retired writers, saturating-free (0..3), updated with same rules as REQ-014/015.
REQ-022 flush SHALL clear all cnt, lie_valid and infl_cnt at next edge, overriding any same-cycle issue/retire.
REQ-023 Decrement of a zero counter SHALL be ignored (counter stays 0) and flagged by a simulation assertion.
REQ-024 Latency: state effects of fire/retire visible on outputs exactly one cycle later.

Reset
REQ-025 Asserting resetn low SHALL immediately clear all cnt, lie_valid, lie_dest, infl_cnt; outputs ds_stall=0, rs_pending=0, rt_pending=0, infl_cnt=0.
REQ-026 Reset mid-operation SHALL discard in-flight state identically to flush; release SHALL be synchronised by the top-level reset synchroniser, not this block.

Structure
REQ-027 NREG, MAX_INFL, GPR index width and bus-width macros SHALL live in the shared mycpu.h header.
REQ-028 One sub-module, sb_counter (2-bit up/down counter with flush and zero-guard), SHALL be instantiated per register via generate.

Verification
REQ-029 Issue addu $3 (gr_we, dest=3) then retire $3 two cycles later -> cnt[3]=1 for two cycles, then 0; rs_pending for reader of $3 high only while cnt=1.
REQ-030 Issue lw $5, next ID instruction reads rs=5 -> ds_stall=1 until es_fire, then 0 next cycle.
REQ-031 Three back-to-back writers to $7 without retire, fourth writer to $7 in ID -> ds_stall=1 until a ws_retire of $7.
REQ-032 Same-cycle ds_fire dest=9 and ws_retire dest=9 with cnt[9]=1 -> cnt[9] stays 1.
REQ-033 flush with cnt[4]=2, lie_valid=1 -> next cycle all counters 0, ds_stall=0, infl_cnt=0.
REQ-034 Writer with dest=0 issued, then reader of $0 -> no pending, no stall; resetn pulsed low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared widths, defaults and types for the issue scoreboard slice.
package issue_scoreboard_pkg;

    localparam int unsigned NREG_DEF     = 32;
    localparam int unsigned MAX_INFL_DEF = 3;
    localparam int unsigned GPR_W        = 5;
    localparam int unsigned CNT_W        = 2;

    typedef logic [GPR_W-1:0] gpr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Load sitting in EX whose result is not yet forwardable
    typedef struct packed {
        logic valid;
        gpr_t dest;
    } lie_t;

    function automatic logic is_tracked(input logic we, input gpr_t dest);
        return we && (dest != '0);
    endfunction

endpackage

// File: rtl/issue_scoreboard_if.sv
// Pipeline-to-scoreboard bundle: ID/EX/WB events in, hazard status out.
interface issue_scoreboard_if;
    import issue_scoreboard_pkg::*;

    gpr_t ds_rs;
    gpr_t ds_rt;
    logic ds_rs_used;
    logic ds_rt_used;
    gpr_t ds_dest;
    logic ds_gr_we;
    logic ds_is_load;
    logic ds_fire;
    logic es_fire;
    logic ws_retire;
    gpr_t ws_dest;
    logic flush;

    logic ds_stall;
    logic rs_pending;
    logic rt_pending;
    cnt_t infl_cnt;

    modport master (
        output ds_rs, ds_rt, ds_rs_used, ds_rt_used, ds_dest, ds_gr_we,
               ds_is_load, ds_fire, es_fire, ws_retire, ws_dest, flush,
        input  ds_stall, rs_pending, rt_pending, infl_cnt
    );

    modport slave (
        input  ds_rs, ds_rt, ds_rs_used, ds_rt_used, ds_dest, ds_gr_we,
               ds_is_load, ds_fire, es_fire, ws_retire, ws_dest, flush,
        output ds_stall, rs_pending, rt_pending, infl_cnt
    );

endinterface

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register pending-writer counter: up on issue, down on retire,
// cleared by flush; a decrement of an idle counter is dropped.
module sb_counter
    import issue_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic flush,
    input  logic inc,
    input  logic dec,
    output cnt_t cnt
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (resetn && !flush) begin
            assert (!(dec && !inc && (cnt == '0)))
                else $error("sb_counter: retire of a register with no pending writer");
        end
    end
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: tracks in-flight GPR writers and the load in EX,
// and raises ID stall for load-use and per-register writer overflow.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned MAX_INFL = MAX_INFL_DEF
) (
    input  logic               clk,
    input  logic               resetn,
    issue_scoreboard_if.slave  sb
);

    cnt_t cnt [NREG];
    lie_t lie_q;
    cnt_t infl_q;

    logic issue;
    logic retire;
    logic same_reg;
    logic retire_eff;
    logic load_use;
    logic waw_full;

    assign issue    = sb.ds_fire && is_tracked(sb.ds_gr_we, sb.ds_dest);
    assign retire   = sb.ws_retire && (sb.ws_dest != '0);
    assign same_reg = issue && retire && (sb.ds_dest == sb.ws_dest);

    // A retire counts toward the total only if its register really had a
    // writer pending, or it cancels against a same-cycle issue.
    assign retire_eff = retire && ((cnt[sb.ws_dest] != '0) || same_reg);

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        if (r == 0) begin : g_zero
            assign cnt[r] = '0;
        end else begin : g_reg
            sb_counter u_cnt (
                .clk    (clk),
                .resetn (resetn),
                .flush  (sb.flush),
                .inc    (issue  && (sb.ds_dest == GPR_W'(r))),
                .dec    (retire && (sb.ws_dest == GPR_W'(r))),
                .cnt    (cnt[r])
            );
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            infl_q <= '0;
        end else if (sb.flush) begin
            infl_q <= '0;
        end else begin
            case ({issue, retire_eff})
                2'b10:   infl_q <= infl_q + CNT_W'(1);
                2'b01:   infl_q <= infl_q - CNT_W'(1);
                default: infl_q <= infl_q;
            endcase
        end
    end

    // A newly issued load replaces the one leaving EX in the same cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lie_q <= '0;
        end else if (sb.flush) begin
            lie_q.valid <= 1'b0;
        end else if (sb.ds_fire && sb.ds_is_load) begin
            lie_q <= '{valid: 1'b1, dest: sb.ds_dest};
        end else if (sb.es_fire) begin
            lie_q.valid <= 1'b0;
        end
    end

    always_comb begin
        load_use = lie_q.valid && (lie_q.dest != '0) &&
                   ((sb.ds_rs_used && (sb.ds_rs == lie_q.dest)) ||
                    (sb.ds_rt_used && (sb.ds_rt == lie_q.dest)));
        waw_full = sb.ds_gr_we && (cnt[sb.ds_dest] == CNT_W'(MAX_INFL));
    end

    assign sb.ds_stall   = load_use || waw_full;
    assign sb.rs_pending = sb.ds_rs_used && (cnt[sb.ds_rs] != '0);
    assign sb.rt_pending = sb.ds_rt_used && (cnt[sb.ds_rt] != '0);
    assign sb.infl_cnt   = infl_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench: driver pushes per-cycle expectations from a queue-of-writers model, monitor compares.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    issue_scoreboard_if sb_if ();

    issue_scoreboard #(.NREG(32), .MAX_INFL(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb_if)
    );

    typedef struct {
        logic       stall;
        logic       rsp;
        logic       rtp;
        logic [1:0] infl;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   wq[$];       // destinations of issued-not-retired writers, oldest first
    logic lie_v;
    int   lie_d;
    int   checks   = 0;
    int   failures = 0;
    string cur_tag = "reset";

    function automatic int pending_of(input int r);
        int n = 0;
        foreach (wq[i]) if (wq[i] == r) n++;
        return n;
    endfunction

    function automatic logic model_stall();
        logic lu;
        int   rs, rt, d;
        rs = int'(sb_if.ds_rs);
        rt = int'(sb_if.ds_rt);
        d  = int'(sb_if.ds_dest);
        lu = lie_v && (lie_d != 0) &&
             ((sb_if.ds_rs_used && rs == lie_d) || (sb_if.ds_rt_used && rt == lie_d));
        return lu || (sb_if.ds_gr_we && pending_of(d) == 3);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s [%s] actual=%0d expected=%0d at %0t", name, cur_tag, act, exp, $time);
        end
    endtask

    task automatic idle();
        sb_if.ds_rs = '0;      sb_if.ds_rt = '0;
        sb_if.ds_rs_used = 0;  sb_if.ds_rt_used = 0;
        sb_if.ds_dest = '0;    sb_if.ds_gr_we = 0;
        sb_if.ds_is_load = 0;  sb_if.ds_fire = 0;
        sb_if.es_fire = 0;     sb_if.ws_retire = 0;
        sb_if.ws_dest = '0;    sb_if.flush = 0;
    endtask

    // Record this cycle's expected outputs, advance the model, move to the next cycle
    task automatic step(input string tag);
        exp_t e;
        int   d;
        if (!resetn) begin
            wq.delete();
            lie_v = 0;
            lie_d = 0;
        end
        e.stall = model_stall();
        e.rsp   = sb_if.ds_rs_used && pending_of(int'(sb_if.ds_rs)) != 0;
        e.rtp   = sb_if.ds_rt_used && pending_of(int'(sb_if.ds_rt)) != 0;
        e.infl  = 2'(wq.size());
        e.tag   = tag;
        exp_q.push_back(e);
        if (resetn) begin
            if (sb_if.flush) begin
                wq.delete();
                lie_v = 0;
            end else begin
                d = int'(sb_if.ds_dest);
                if (sb_if.ds_fire && sb_if.ds_gr_we && d != 0) wq.push_back(d);
                if (sb_if.ws_retire && sb_if.ws_dest != '0) begin
                    for (int i = 0; i < wq.size(); i++) begin
                        if (wq[i] == int'(sb_if.ws_dest)) begin
                            wq.delete(i);
                            break;
                        end
                    end
                end
                if (sb_if.ds_fire && sb_if.ds_is_load) begin
                    lie_v = 1;
                    lie_d = d;
                end else if (sb_if.es_fire) begin
                    lie_v = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fire_wr(input int dest, input logic load);
        idle();
        sb_if.ds_fire = 1; sb_if.ds_gr_we = 1;
        sb_if.ds_dest = 5'(dest); sb_if.ds_is_load = load;
    endtask

    task automatic read_rs(input int r);
        sb_if.ds_rs = 5'(r); sb_if.ds_rs_used = 1;
    endtask

    task automatic retire(input int r);
        sb_if.ws_retire = 1; sb_if.ws_dest = 5'(r);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cur_tag = e.tag;
                chk("ds_stall",   int'(sb_if.ds_stall),   int'(e.stall));
                chk("rs_pending", int'(sb_if.rs_pending), int'(e.rsp));
                chk("rt_pending", int'(sb_if.rt_pending), int'(e.rtp));
                chk("infl_cnt",   int'(sb_if.infl_cnt),   int'(e.infl));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : driver
        int   n_ret;
        logic tracked;
        idle();
        lie_v  = 0;
        lie_d  = 0;
        resetn = 0;
        @(posedge clk); #1;
        sb_if.ds_rs = 5'd3; sb_if.ds_rs_used = 1; sb_if.ds_gr_we = 1;
        step("reset_state");
        resetn = 1;

        // single writer then retire; reader of $3 sees pending only while in flight
        fire_wr(3, 0);            step("addu3_issue");
        idle(); read_rs(3);       step("addu3_p1");
        idle(); read_rs(3);       step("addu3_p2");
        idle(); read_rs(3); retire(3); step("addu3_ret");
        idle(); read_rs(3);       step("addu3_clear");

        // load-use on $5 until the load leaves EX
        fire_wr(5, 1);            step("lw5_issue");
        idle(); read_rs(5);       step("lw5_use1");
        idle(); read_rs(5);       step("lw5_use2");
        idle(); read_rs(5); sb_if.es_fire = 1; step("lw5_esfire");
        idle(); read_rs(5);       step("lw5_free");
        idle(); retire(5);        step("lw5_ret");

        // three writers to $7 saturate it; a fourth in ID stalls until a retire lands
        repeat (3) begin fire_wr(7, 0); step("waw7_issue"); end
        idle(); sb_if.ds_gr_we = 1; sb_if.ds_dest = 5'd7; step("waw7_stall");
        idle(); sb_if.ds_gr_we = 1; sb_if.ds_dest = 5'd7; retire(7); step("waw7_ret");
        idle(); sb_if.ds_gr_we = 1; sb_if.ds_dest = 5'd7; step("waw7_free");
        idle(); retire(7);        step("waw7_ret2");
        idle(); retire(7);        step("waw7_ret3");

        // same-cycle issue and retire of $9 cancels
        fire_wr(9, 0);            step("r9_issue");
        fire_wr(9, 0); retire(9); step("r9_both");
        idle(); read_rs(9);       step("r9_hold");
        idle(); retire(9); sb_if.ds_rt = 5'd9; sb_if.ds_rt_used = 1; step("r9_ret");
        idle(); sb_if.ds_rt = 5'd9; sb_if.ds_rt_used = 1; step("r9_clear");

        // flush with two writers of $4 and a load in EX
        fire_wr(4, 0);            step("fl_issue");
        fire_wr(4, 1);            step("fl_load");
        idle(); read_rs(4); sb_if.flush = 1; fire_wr(4, 0); sb_if.flush = 1; read_rs(4); step("fl_flush");
        idle(); read_rs(4); sb_if.ds_rt = 5'd4; sb_if.ds_rt_used = 1; sb_if.ds_gr_we = 1; sb_if.ds_dest = 5'd4; step("fl_after");

        // $0 is never tracked; reset mid-flight clears immediately
        fire_wr(0, 1);            step("z_issue");
        idle(); read_rs(0); sb_if.ds_rt_used = 1; step("z_read");
        fire_wr(6, 0);            step("z_w6");
        fire_wr(6, 1);            step("z_lw6");
        idle(); read_rs(6); resetn = 0; step("rst_mid");
        resetn = 1;
        idle(); read_rs(6); sb_if.ds_gr_we = 1; sb_if.ds_dest = 5'd6; step("rst_after");

        // randomized pipeline traffic kept within three writers in flight
        for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
            idle();
            sb_if.ds_rs      = 5'($urandom_range(0, 7));
            sb_if.ds_rt      = 5'($urandom_range(0, 7));
            sb_if.ds_rs_used = 1'($urandom_range(0, 1));
            sb_if.ds_rt_used = 1'($urandom_range(0, 1));
            sb_if.ds_dest    = 5'($urandom_range(0, 7));
            sb_if.ds_gr_we   = ($urandom_range(0, 3) != 0);
            sb_if.ds_is_load = sb_if.ds_gr_we && ($urandom_range(0, 3) == 0);
            sb_if.es_fire    = 1'($urandom_range(0, 1));
            n_ret = 0;
            if (wq.size() != 0 && $urandom_range(0, 1) == 1) begin
                retire(wq[0]);
                n_ret = 1;
            end else if ($urandom_range(0, 15) == 0) begin
                retire(0);
            end
            tracked = sb_if.ds_gr_we && sb_if.ds_dest != '0;
            if (!model_stall() && (wq.size() - n_ret + int'(tracked)) <= 3 &&
                $urandom_range(0, 9) < 7)
                sb_if.ds_fire = 1;
            sb_if.flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) resetn = 0;
            step("random");
            resetn = 1;
        end

        idle();
        @(negedge clk);
        #1;
        cur_tag = "drain";
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
